// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain controller:
// register addresses, word width, FSM state type and word packing.
package max7219_pkg;

  localparam int C_WORD_W = 16;

  localparam logic [3:0] REG_NOOP         = 4'h0;
  localparam logic [3:0] REG_DIGIT0       = 4'h1;
  localparam logic [3:0] REG_DIGIT1       = 4'h2;
  localparam logic [3:0] REG_DIGIT2       = 4'h3;
  localparam logic [3:0] REG_DIGIT3       = 4'h4;
  localparam logic [3:0] REG_DIGIT4       = 4'h5;
  localparam logic [3:0] REG_DIGIT5       = 4'h6;
  localparam logic [3:0] REG_DIGIT6       = 4'h7;
  localparam logic [3:0] REG_DIGIT7       = 4'h8;
  localparam logic [3:0] REG_DECODE       = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  // One device word: upper nibble unused by the MAX7219, then address, then data.
  function automatic logic [C_WORD_W-1:0] build_word(input logic [3:0] addr,
                                                     input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_chain_ctrl_if.sv
// Command bus between display-content logic (master) and the chain
// controller (slave): one register address plus one data byte per device.
interface max7219_chain_ctrl_if #(
  parameter int G_MATRIX_NB = 2
);

  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic [3:0]               i_cmd_addr;
  logic [8*G_MATRIX_NB-1:0] i_cmd_data;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    output i_cmd_valid,
    output i_cmd_addr,
    output i_cmd_data,
    input  o_cmd_ready,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_addr,
    input  i_cmd_data,
    output o_cmd_ready,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/max7219_serializer.sv
// Datapath half of the chain controller: frame shift register, serial
// clock phase divider and remaining-bit counter. The FSM in the top
// decides when to capture, when phases run and when to advance a bit.
module max7219_serializer
  import max7219_pkg::*;
#(
  parameter int G_MATRIX_NB = 2,
  parameter int G_CLK_DIV   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_load,
  input  logic [C_WORD_W*G_MATRIX_NB-1:0] frame_in,
  input  logic                            div_run,
  input  logic                            shift,
  output logic                            div_end,
  output logic                            msb_next,
  output logic                            last
);

  localparam int C_FRAME_W = C_WORD_W * G_MATRIX_NB;
  localparam int C_BIT_CW  = $clog2(C_FRAME_W + 1);
  localparam int C_DIV_CW  = $clog2(G_CLK_DIV + 1);
  localparam logic [C_DIV_CW-1:0] C_DIV_LAST  = C_DIV_CW'(G_CLK_DIV - 1);
  localparam logic [C_BIT_CW-1:0] C_BIT_FULL  = C_BIT_CW'(C_FRAME_W);
  localparam logic [C_BIT_CW-1:0] C_BIT_ONE   = C_BIT_CW'(1);

  logic [C_FRAME_W-1:0] shreg;
  logic [C_BIT_CW-1:0]  bit_cnt;
  logic [C_DIV_CW-1:0]  div_cnt;

  assign div_end = div_run && (div_cnt == C_DIV_LAST);
  assign last    = (bit_cnt == C_BIT_ONE);

  // Phase divider: restarts at every phase boundary and stays parked while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!div_run || div_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + C_DIV_CW'(1);
    end
  end

  // Frame register and bit counter: capture on accept, advance one bit per serial clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (frame_load) begin
      shreg   <= frame_in;
      bit_cnt <= C_BIT_FULL;
    end else if (shift) begin
      shreg <= {shreg[C_FRAME_W-2:0], 1'b0};
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - C_BIT_ONE;
      end
    end
  end

  // Bit that will be at the head of the frame after this edge, so din can be registered.
  always_comb begin
    msb_next = shreg[C_FRAME_W-1];
    if (frame_load) begin
      msb_next = frame_in[C_FRAME_W-1];
    end else if (shift) begin
      msb_next = shreg[C_FRAME_W-2];
    end
  end

endmodule

// File: rtl/max7219_chain_ctrl.sv
// Sequences one register write into every MAX7219 of a daisy chain:
// shifts the whole chain frame out MSB first (farthest device first),
// then strobes load so all devices latch together. All pins are registered.
module max7219_chain_ctrl
  import max7219_pkg::*;
#(
  parameter int G_MATRIX_NB = 2,
  parameter int G_CLK_DIV   = 4,
  parameter int G_LOAD_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  max7219_chain_ctrl_if.slave cmd,
  output logic                o_max7219_clk,
  output logic                o_max7219_din,
  output logic                o_max7219_load
);

  localparam int C_FRAME_W = C_WORD_W * G_MATRIX_NB;
  localparam int C_LOAD_CW = $clog2(G_LOAD_W + 1);
  localparam logic [C_LOAD_CW-1:0] C_LOAD_LAST = C_LOAD_CW'(G_LOAD_W - 1);

  if (G_MATRIX_NB < 1 || G_MATRIX_NB > 8) begin : g_bad_matrix_nb
    $error("max7219_chain_ctrl: G_MATRIX_NB must be in 1..8");
  end
  if (G_CLK_DIV < 1) begin : g_bad_clk_div
    $error("max7219_chain_ctrl: G_CLK_DIV must be >= 1");
  end
  if (G_LOAD_W < 1) begin : g_bad_load_w
    $error("max7219_chain_ctrl: G_LOAD_W must be >= 1");
  end

  state_t               state;
  state_t               state_next;
  logic [C_LOAD_CW-1:0] load_cnt;
  logic [C_FRAME_W-1:0] frame;
  logic                 frame_load;
  logic                 shift;
  logic                 div_run;
  logic                 div_end;
  logic                 msb_next;
  logic                 last;
  logic                 ready_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 sclk_d;
  logic                 din_d;
  logic                 load_d;

  assign div_run = (state == SHIFT_LO) || (state == SHIFT_HI);

  max7219_serializer #(
    .G_MATRIX_NB (G_MATRIX_NB),
    .G_CLK_DIV   (G_CLK_DIV)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .frame_load (frame_load),
    .frame_in   (frame),
    .div_run    (div_run),
    .shift      (shift),
    .div_end    (div_end),
    .msb_next   (msb_next),
    .last       (last)
  );

  // Chain frame: device k word at slice k, so the highest device leaves first.
  always_comb begin
    frame = '0;
    for (int k = 0; k < G_MATRIX_NB; k++) begin
      frame[k*C_WORD_W +: C_WORD_W] = build_word(cmd.i_cmd_addr, cmd.i_cmd_data[k*8 +: 8]);
    end
  end

  // Next state plus the values every output pin takes after this edge.
  always_comb begin
    state_next = state;
    frame_load = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd.i_cmd_valid) begin
          frame_load = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          shift      = 1'b1;
          state_next = last ? LOAD : SHIFT_LO;
        end
      end
      LOAD: begin
        if (load_cnt == C_LOAD_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ready_d = (state_next == IDLE);
    busy_d  = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) || (state_next == LOAD);
    done_d  = (state_next == DONE);
    sclk_d  = (state_next == SHIFT_HI);
    load_d  = (state_next == LOAD);
    din_d   = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ? msb_next : 1'b0;
  end

  // State register and registered pins; reset drops any frame in flight without a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cmd.o_cmd_ready <= 1'b1;
      cmd.o_busy      <= 1'b0;
      cmd.o_done      <= 1'b0;
      o_max7219_clk   <= 1'b0;
      o_max7219_din   <= 1'b0;
      o_max7219_load  <= 1'b0;
    end else begin
      state           <= state_next;
      cmd.o_cmd_ready <= ready_d;
      cmd.o_busy      <= busy_d;
      cmd.o_done      <= done_d;
      o_max7219_clk   <= sclk_d;
      o_max7219_din   <= din_d;
      o_max7219_load  <= load_d;
    end
  end

  // Load strobe width counter, running only while in LOAD.
  always_ff @(posedge clk) begin
    if (rst || state != LOAD) begin
      load_cnt <= '0;
    end else begin
      load_cnt <= load_cnt + C_LOAD_CW'(1);
    end
  end

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Directed bench for the MAX7219 chain controller: a two-device instance
// with default timing and a one-device instance with the fastest timing,
// each feeding a small behavioural model of the chained MAX7219s.
module tb_max7219_chain_ctrl;
  import max7219_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max7219_chain_ctrl_if #(.G_MATRIX_NB(2)) if0 ();
  max7219_chain_ctrl_if #(.G_MATRIX_NB(1)) if1 ();

  logic sclk0, din0, load0;
  logic sclk1, din1, load1;

  max7219_chain_ctrl #(.G_MATRIX_NB(2), .G_CLK_DIV(4), .G_LOAD_W(2)) dut0 (
    .clk(clk), .rst(rst), .cmd(if0),
    .o_max7219_clk(sclk0), .o_max7219_din(din0), .o_max7219_load(load0)
  );

  max7219_chain_ctrl #(.G_MATRIX_NB(1), .G_CLK_DIV(1), .G_LOAD_W(1)) dut1 (
    .clk(clk), .rst(rst), .cmd(if1),
    .o_max7219_clk(sclk1), .o_max7219_din(din1), .o_max7219_load(load1)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] chain0;
  logic [15:0] chain1;
  int          edges0 = 0;
  int          edges1 = 0;
  int          loads0 = 0;
  int          loads1 = 0;
  logic [7:0]  emu0 [0:1][0:15];
  logic [7:0]  emu1 [0:15];

  // Chain model: each serial clock rising edge pushes din into the chain shift path.
  always @(posedge sclk0) begin
    chain0 = {chain0[30:0], din0};
    edges0++;
  end

  // Load rising edge: every device latches the word currently held in its slot.
  always @(posedge load0) begin
    for (int k = 0; k < 2; k++) emu0[k][chain0[16*k+8 +: 4]] = chain0[16*k +: 8];
    loads0++;
  end

  // Same chain model for the single-device instance.
  always @(posedge sclk1) begin
    chain1 = {chain1[14:0], din1};
    edges1++;
  end

  // Single-device latch.
  always @(posedge load1) begin
    emu1[chain1[11:8]] = chain1[7:0];
    loads1++;
  end

  int         load_first, load_last, load_n, done_cyc, done_n, ready_ret;
  logic       busy_c1, ready_c1;
  int         e_start, l_start;
  logic [3:0] pend_addr;
  logic [15:0] pend_data;

  task automatic accept0(input logic [3:0] a, input logic [15:0] d);
    if0.i_cmd_valid = 1'b1;
    if0.i_cmd_addr  = a;
    if0.i_cmd_data  = d;
    for (int i = 0; i < 600 && !if0.o_cmd_ready; i++) begin @(posedge clk); #1; end
    tests++;
    if (if0.o_cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL accept0_wait: ready=%b required 1", if0.o_cmd_ready); end
    e_start = edges0;
    l_start = loads0;
    @(posedge clk); #1;
    if0.i_cmd_valid = 1'b0;
    if0.i_cmd_addr  = ~a;
    if0.i_cmd_data  = ~d;
  endtask

  // Steps cycles 1..ncyc of a frame (entered at cycle 1) recording pin timing.
  task automatic track0(input int ncyc, input int raise_at);
    load_first = 0; load_last = 0; load_n = 0; done_cyc = 0; done_n = 0; ready_ret = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) begin busy_c1 = if0.o_busy; ready_c1 = if0.o_cmd_ready; end
      if (load0) begin if (load_first == 0) load_first = c; load_last = c; load_n++; end
      if (if0.o_done) begin done_n++; done_cyc = c; end
      if (if0.o_cmd_ready && ready_ret == 0) ready_ret = c;
      if (c == raise_at) begin
        if0.i_cmd_valid = 1'b1;
        if0.i_cmd_addr  = pend_addr;
        if0.i_cmd_data  = pend_data;
      end
    end
  endtask

  task automatic test_reset();
    logic seen_done;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({if0.o_cmd_ready, if0.o_busy, if0.o_done, sclk0, din0, load0} !== 6'b100000) begin
      fails++; $display("[TB] FAIL reset_dut0: rdy/busy/done/clk/din/load=%b required 100000",
                        {if0.o_cmd_ready, if0.o_busy, if0.o_done, sclk0, din0, load0});
    end
    tests++;
    if ({if1.o_cmd_ready, if1.o_busy, if1.o_done, sclk1, din1, load1} !== 6'b100000) begin
      fails++; $display("[TB] FAIL reset_dut1: rdy/busy/done/clk/din/load=%b required 100000",
                        {if1.o_cmd_ready, if1.o_busy, if1.o_done, sclk1, din1, load1});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (if0.o_done !== 1'b0 || if1.o_done !== 1'b0) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_no_done: done seen=%b required 0", seen_done); end
  endtask

  task automatic test_shutdown();
    accept0(REG_SHUTDOWN, 16'h0101);
    track0(262, 0);
    tests++;
    if (edges0 - e_start != 32) begin fails++; $display("[TB] FAIL shut_edges: got %0d required 32", edges0 - e_start); end
    tests++;
    if (chain0 !== 32'h0C010C01) begin fails++; $display("[TB] FAIL shut_stream: got %h required 0c010c01", chain0); end
    tests++;
    if ({busy_c1, ready_c1} !== 2'b10) begin fails++; $display("[TB] FAIL shut_cycle1: busy,ready=%b required 10", {busy_c1, ready_c1}); end
    tests++;
    if (load_first != 257 || load_last != 258 || load_n != 2) begin
      fails++; $display("[TB] FAIL shut_load: first=%0d last=%0d n=%0d required 257 258 2", load_first, load_last, load_n);
    end
    tests++;
    if (done_cyc != 259 || done_n != 1) begin fails++; $display("[TB] FAIL shut_done: cycle=%0d n=%0d required 259 1", done_cyc, done_n); end
    tests++;
    if (ready_ret != 260) begin fails++; $display("[TB] FAIL shut_ready: cycle=%0d required 260", ready_ret); end
    tests++;
    if (loads0 - l_start != 1) begin fails++; $display("[TB] FAIL shut_load_edges: got %0d required 1", loads0 - l_start); end
    tests++;
    if (emu0[0][REG_SHUTDOWN] !== 8'h01 || emu0[1][REG_SHUTDOWN] !== 8'h01) begin
      fails++; $display("[TB] FAIL shut_emu: dev0=%h dev1=%h required 01 01", emu0[0][REG_SHUTDOWN], emu0[1][REG_SHUTDOWN]);
    end
  endtask

  task automatic test_digit();
    accept0(REG_DIGIT0, 16'hAA55);
    track0(262, 0);
    tests++;
    if (chain0 !== 32'h01AA0155) begin fails++; $display("[TB] FAIL digit_stream: got %h required 01aa0155", chain0); end
    tests++;
    if (emu0[0][REG_DIGIT0] !== 8'h55) begin fails++; $display("[TB] FAIL digit_dev0: got %h required 55", emu0[0][REG_DIGIT0]); end
    tests++;
    if (emu0[1][REG_DIGIT0] !== 8'hAA) begin fails++; $display("[TB] FAIL digit_dev1: got %h required aa", emu0[1][REG_DIGIT0]); end
    tests++;
    if (done_cyc != 259) begin fails++; $display("[TB] FAIL digit_done: cycle=%0d required 259", done_cyc); end
  endtask

  task automatic test_back_to_back();
    pend_addr = 4'h3;
    pend_data = 16'h817E;
    accept0(4'h2, 16'h1234);
    track0(260, 5);
    tests++;
    if (ready_ret != 260) begin fails++; $display("[TB] FAIL b2b_ready: first ready cycle=%0d required 260", ready_ret); end
    tests++;
    if (done_cyc != 259) begin fails++; $display("[TB] FAIL b2b_done1: cycle=%0d required 259", done_cyc); end
    e_start = edges0;
    l_start = loads0;
    @(posedge clk); #1;
    if0.i_cmd_valid = 1'b0;
    tests++;
    if ({if0.o_cmd_ready, if0.o_busy} !== 2'b01) begin fails++; $display("[TB] FAIL b2b_accept: ready,busy=%b required 01", {if0.o_cmd_ready, if0.o_busy}); end
    track0(262, 0);
    tests++;
    if (edges0 - e_start != 32) begin fails++; $display("[TB] FAIL b2b_edges: got %0d required 32", edges0 - e_start); end
    tests++;
    if (chain0 !== 32'h0381037E) begin fails++; $display("[TB] FAIL b2b_stream: got %h required 0381037e", chain0); end
    tests++;
    if (done_cyc != 259) begin fails++; $display("[TB] FAIL b2b_done2: cycle=%0d required 259", done_cyc); end
    tests++;
    if (emu0[1][2] !== 8'h12 || emu0[0][2] !== 8'h34) begin
      fails++; $display("[TB] FAIL b2b_emu_first: dev1=%h dev0=%h required 12 34", emu0[1][2], emu0[0][2]);
    end
    tests++;
    if (emu0[1][3] !== 8'h81 || emu0[0][3] !== 8'h7E) begin
      fails++; $display("[TB] FAIL b2b_emu_second: dev1=%h dev0=%h required 81 7e", emu0[1][3], emu0[0][3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] snap [0:1][0:15];
    int diff;
    snap = emu0;
    accept0(REG_DIGIT0, 16'hFFFF);
    track0(40, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({if0.o_cmd_ready, if0.o_busy, if0.o_done, sclk0, din0, load0} !== 6'b100000) begin
      fails++; $display("[TB] FAIL midrst_pins: rdy/busy/done/clk/din/load=%b required 100000",
                        {if0.o_cmd_ready, if0.o_busy, if0.o_done, sclk0, din0, load0});
    end
    rst = 1'b0;
    track0(300, 0);
    tests++;
    if (done_n != 0 || load_n != 0 || loads0 - l_start != 0) begin
      fails++; $display("[TB] FAIL midrst_quiet: done=%0d load_cycles=%0d load_edges=%0d required 0 0 0", done_n, load_n, loads0 - l_start);
    end
    diff = 0;
    for (int k = 0; k < 2; k++) for (int r = 0; r < 16; r++) if (emu0[k][r] !== snap[k][r]) diff++;
    tests++;
    if (diff != 0) begin fails++; $display("[TB] FAIL midrst_emu: %0d registers changed, required 0", diff); end
    accept0(REG_INTENSITY, 16'h0F07);
    track0(262, 0);
    tests++;
    if (chain0 !== 32'h0A0F0A07) begin fails++; $display("[TB] FAIL midrst_stream: got %h required 0a0f0a07", chain0); end
    tests++;
    if (done_cyc != 259 || done_n != 1) begin fails++; $display("[TB] FAIL midrst_done: cycle=%0d n=%0d required 259 1", done_cyc, done_n); end
    tests++;
    if (emu0[1][REG_INTENSITY] !== 8'h0F || emu0[0][REG_INTENSITY] !== 8'h07) begin
      fails++; $display("[TB] FAIL midrst_emu_new: dev1=%h dev0=%h required 0f 07", emu0[1][REG_INTENSITY], emu0[0][REG_INTENSITY]);
    end
  endtask

  task automatic test_small_cfg();
    int tog_err;
    if1.i_cmd_valid = 1'b1;
    if1.i_cmd_addr  = REG_SCAN_LIMIT;
    if1.i_cmd_data  = 8'h07;
    for (int i = 0; i < 100 && !if1.o_cmd_ready; i++) begin @(posedge clk); #1; end
    tests++;
    if (if1.o_cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL small_wait: ready=%b required 1", if1.o_cmd_ready); end
    e_start = edges1;
    l_start = loads1;
    @(posedge clk); #1;
    if1.i_cmd_valid = 1'b0;
    if1.i_cmd_data  = 8'hF8;
    tog_err = 0; load_first = 0; load_n = 0; done_cyc = 0; done_n = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c <= 32 && sclk1 !== (c % 2 == 0)) tog_err++;
      if (load1) begin if (load_first == 0) load_first = c; load_n++; end
      if (if1.o_done) begin done_n++; done_cyc = c; end
    end
    tests++;
    if (tog_err != 0) begin fails++; $display("[TB] FAIL small_toggle: %0d cycles wrong, required 0", tog_err); end
    tests++;
    if (edges1 - e_start != 16) begin fails++; $display("[TB] FAIL small_edges: got %0d required 16", edges1 - e_start); end
    tests++;
    if (chain1 !== 16'h0B07) begin fails++; $display("[TB] FAIL small_stream: got %h required 0b07", chain1); end
    tests++;
    if (load_first != 33 || load_n != 1) begin fails++; $display("[TB] FAIL small_load: first=%0d n=%0d required 33 1", load_first, load_n); end
    tests++;
    if (done_cyc != 34 || done_n != 1) begin fails++; $display("[TB] FAIL small_done: cycle=%0d n=%0d required 34 1", done_cyc, done_n); end
    tests++;
    if (emu1[REG_SCAN_LIMIT] !== 8'h07) begin fails++; $display("[TB] FAIL small_emu: got %h required 07", emu1[REG_SCAN_LIMIT]); end
  endtask

  // Single sequencer: scenarios run back to back, then the summary.
  initial begin
    if0.i_cmd_valid = 1'b0;
    if0.i_cmd_addr  = 4'h0;
    if0.i_cmd_data  = 16'h0000;
    if1.i_cmd_valid = 1'b0;
    if1.i_cmd_addr  = 4'h0;
    if1.i_cmd_data  = 8'h00;
    pend_addr = 4'h0;
    pend_data = 16'h0000;
    test_reset();
    test_shutdown();
    test_digit();
    test_back_to_back();
    test_reset_mid_frame();
    test_small_cfg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max7219_chain_ctrl.md
Name: max7219_chain_ctrl

Overview:
- Controller that sequences register writes into a daisy chain of G_MATRIX_NB cascaded MAX7219 8x8 LED matrix drivers over the 3-wire interface (clock, data in, load).
- Accepts one command per frame: a register address common to all devices plus one data byte per device.
- Serialises the full chain frame, then pulses load so every device latches its word simultaneously.
- Sits between display-content logic and the chained MAX7219 pins, or the matrix emulator in benches.

Parameters:
- G_MATRIX_NB, 2, number of chained devices (legal 1..8).
- G_CLK_DIV, 4, clk cycles per half-period of o_max7219_clk (>=1).
- G_LOAD_W, 2, clk cycles o_max7219_load is held high at end of frame (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  controller idle; command accepted when valid&ready.
- i_cmd_addr  in  4  MAX7219 register address, same for all devices.
- i_cmd_data  in  8*G_MATRIX_NB  byte k = data for device k; device 0 is nearest the controller.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame completion.
- o_max7219_clk  out  1  serial clock.
- o_max7219_din  out  1  serial data, MSB first.
- o_max7219_load  out  1  latch strobe; rising edge latches.

Behaviour:
- All outputs are registered.
- Reset values: o_cmd_ready=1; o_busy=0; o_done=0; o_max7219_clk=0; o_max7219_din=0; o_max7219_load=0; FSM=IDLE.
- Word per device: {4'h0, i_cmd_addr, byte}, 16 bits. Frame width N = 16*G_MATRIX_NB.
- Frame order: device G_MATRIX_NB-1 word is shifted first, device 0 word last, so after N bits each word sits in its own device.
- Frame is captured into an N-bit shift register on accept (cycle 0). Inputs are don't-care afterwards.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
  - IDLE: ready=1. On valid, capture the frame and go to SHIFT_LO; ready drops next cycle.
  - SHIFT_LO: held G_CLK_DIV cycles; sclk=0; din = current MSB. Then go to SHIFT_HI.
  - SHIFT_HI: held G_CLK_DIV cycles; sclk=1; din unchanged (stable across the rising edge). On exit, shift left and decrement the bit counter.
    - Go to SHIFT_LO if bits remain, else LOAD.
  - LOAD: G_LOAD_W cycles; load=1, sclk=0, din=0.
  - DONE: 1 cycle; o_done=1, busy=0. Then IDLE.
- o_busy=1 in SHIFT_LO, SHIFT_HI and LOAD.
- Latency with defaults (N=32, D=4, L=2):
  - Shifting occupies cycles 1..256.
  - Load is high in cycles 257-258.
  - o_done pulses in cycle 259.
  - Ready returns in cycle 260.
  - General form: done at 2*D*N + L + 1.
- Valid while not ready: ignored, no queueing. Requester holds valid until accepted.
- Back-to-back commands: the next frame starts no earlier than one cycle after done.
- Reset mid-frame: the next edge forces all outputs to reset values and the FSM to IDLE. No load pulse and no done are emitted. Partially shifted bits are never latched.
- Counters:
  - Divider: $clog2(G_CLK_DIV+1) bits.
  - Bit counter: $clog2(N+1) bits, counting down from N to 0 with no wrap.
- Illegal parameters cause an elaboration-time $error.

Decomposition:
- Package max7219_pkg:
  - Register address constants: NOOP 0x0, DIGIT0..7 0x1..0x8, DECODE 0x9, INTENSITY 0xA, SCAN_LIMIT 0xB, SHUTDOWN 0xC, DISPLAY_TEST 0xF.
  - C_WORD_W = 16.
  - FSM state enum type.
- Sub-module max7219_serializer holds the shift register, clock divider and bit counter, with shift/load/last handshake to the FSM. The FSM and command handshake stay in the top.

Test Plan:
- Reset with rst=1 for 3 cycles, then release -> all pins 0, o_cmd_ready=1, o_busy=0, o_done never pulses.
- Command addr=0xC, data=16'h0101, defaults -> exactly 32 sclk rising edges.
  - Sampled din bitstream is 0x0C01 then 0x0C01.
  - Load high cycles 257-258; o_done in 259.
  - Both emulated devices report SHUTDOWN=0x01.
- Command addr=0x1, data[15:8]=0xAA, data[7:0]=0x55 -> stream 0x01AA then 0x0155; emulator device 0 DIGIT0=0x55, device 1 DIGIT0=0xAA.
- Second command with valid held from cycle 5 -> o_cmd_ready stays 0 until cycle 260. That command is accepted in cycle 260, and its frame is bit-exact.
- rst asserted in cycle 40 of a frame -> all outputs 0 next edge; no load edge, no done; emulator contents unchanged; a fresh command afterwards completes normally.
- G_CLK_DIV=1, G_MATRIX_NB=1, G_LOAD_W=1 -> sclk toggles every cycle, 16 rising edges, load high in cycle 33, o_done in cycle 34.
